llsc_monitor: RTL and testbench
===============================

LLSC_MONITOR -- requirements
Module: llsc_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width; link compare uses bits [ADDR_W-1:2] (word granularity).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, max cycles waited for mem_ack_i before the SC is abandoned.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous reset, active-high.
REQ-005 flush  in  1  exception/pipeline flush; breaks the link.
REQ-006 ll_req_i  in  1  LL in MEM stage this cycle.
REQ-007 ll_addr_i  in  ADDR_W  LL byte address.
REQ-008 sc_req_i  in  1  SC in MEM stage this cycle.
REQ-009 sc_addr_i  in  ADDR_W  SC byte address.
REQ-010 sc_data_i  in  32  SC store data.
REQ-011 snoop_we_i  in  1  any other store (own SW/SB/SH or other master) committing this cycle.
REQ-012 snoop_addr_i  in  ADDR_W  address of that store.
REQ-013 mem_we_o  out  1  SC write request to data memory, held until ack/timeout.
REQ-014 mem_addr_o  out  ADDR_W  SC write address.
REQ-015 mem_data_o  out  32  SC write data.
REQ-016 mem_ack_i  in  1  memory accepted write (single-cycle pulse).
REQ-017 LLbit_o  out  1  current link valid.
REQ-018 link_addr_o  out  ADDR_W  linked word address (low 2 bits zero).
REQ-019 sc_done_o  out  1  one-cycle pulse: SC resolved.
REQ-020 sc_result_o  out  1  valid with sc_done_o: 1 success, 0 fail (written to SC rt).
REQ-021 stall_req_o  out  1  pipeline stall request while an SC is unresolved.
REQ-022 bus_err_o  out  1  one-cycle pulse on ack timeout.

Function
REQ-023 States SHALL be IDLE, LINKED, SC_WRITE, SC_DONE; LLbit_o = 1 exactly in LINKED.
REQ-024 ll_req_i in IDLE or LINKED -> LINKED next cycle, link_addr_o = ll_addr_i with [1:0] zeroed (re-link overwrites).
REQ-025 LINKED + snoop_we_i with word-matching snoop_addr_i -> IDLE next cycle; non-matching snoop ignored.
REQ-026 ll_req_i and matching snoop same cycle: ll_req_i wins, new link set.
REQ-027 sc_req_i in LINKED, word match, no matching snoop, no flush same cycle -> SC_WRITE; link cleared on entry.
REQ-028 sc_req_i otherwise (IDLE, mismatch, matching snoop, flush) -> SC_DONE with sc_result_o = 0, no memory write.
REQ-029 sc_req_i and ll_req_i same cycle: sc_req_i has priority, ll_req_i ignored.
REQ-030 SC_WRITE: mem_we_o = 1, mem_addr_o/mem_data_o stable until exit; mem_ack_i -> SC_DONE, result 1.
REQ-031 SC_WRITE: 4-bit wait counter from 0; counter reaching ACK_TIMEOUT without ack -> mem_we_o drop, bus_err_o pulse, SC_DONE, result 0.
REQ-032 SC_DONE: sc_done_o = 1 for exactly one cycle, then IDLE; SC latency: fail 1 cycle, success 1 + ack wait cycles.
REQ-033 stall_req_o SHALL be 1 combinationally from sc_req_i cycle through SC_WRITE, 0 in SC_DONE.
REQ-034 sc_req_i/ll_req_i in SC_WRITE or SC_DONE SHALL be ignored; snoops in SC_WRITE ignored (write committed).
REQ-035 flush in IDLE/LINKED -> IDLE next cycle; flush in SC_WRITE SHALL NOT drop mem_we_o, write completes, sc_done_o suppressed, then IDLE.
REQ-036 flush has priority over ll_req_i same cycle.

Reset
REQ-037 rst asynchronous: state IDLE, link_addr_o 0, counter 0, flush-pending flag 0, all outputs 0 immediately, independent of clk.
REQ-038 rst during SC_WRITE SHALL abandon write (mem_we_o 0) with no sc_done_o.

Structure
REQ-039 State encodings, ACK_TIMEOUT default, SC result values SHALL live in shared defines.v.
REQ-040 Ack-wait counter SHALL be sub-module llsc_timeout_cnt (clear, enable, expired).

Verification
REQ-041 LL 0x100, SC 0x100, ack 2 cycles later -> mem_we_o 0x100/data, sc_done_o result 1, LLbit_o 0 after.
REQ-042 LL 0x100, snoop store 0x102, SC 0x100 -> no mem_we_o, sc_done_o next cycle result 0.
REQ-043 LL 0x100, snoop 0x104, SC 0x103 -> success (word match, snoop elsewhere).
REQ-044 LL 0x200, SC, no ack -> after 15 cycles bus_err_o pulse, result 0, mem_we_o drops.
REQ-045 LL 0x100, SC, flush in SC_WRITE, ack -> write completes, no sc_done_o, IDLE; rst mid-SC_WRITE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/llsc_monitor_pkg.sv
//==============================================================================
// Module      : llsc_monitor_pkg
// Description : Shared state encodings, timeout default and SC result values
//               for the LL/SC reservation monitor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package llsc_monitor_pkg;

    localparam int         c_state_w = 2;
    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_linked   = 2'd1;
    localparam logic [1:0] c_st_sc_write = 2'd2;
    localparam logic [1:0] c_st_sc_done  = 2'd3;

    localparam int c_ack_timeout_def = 15;
    localparam int c_cnt_w           = 4;

    localparam logic c_sc_fail = 1'b0;
    localparam logic c_sc_ok   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/llsc_timeout_cnt.sv
//==============================================================================
// Module      : llsc_timeout_cnt
// Description : Ack-wait counter; flags the last permitted wait cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module llsc_timeout_cnt
    import llsc_monitor_pkg::*;
#(
    parameter int TIMEOUT = c_ack_timeout_def
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_at_limit;

    assign w_at_limit = (r_cnt == c_limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && !w_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The count about to reach TIMEOUT ends the wait, so the write request
    // is held for exactly TIMEOUT cycles without an ack.
    assign expired = enable && w_at_limit;

endmodule

`default_nettype wire

// File: rtl/llsc_monitor.sv
//==============================================================================
// Module      : llsc_monitor
// Description : Load-linked / store-conditional reservation monitor with
//               SC write handshake, ack timeout and flush handling.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module llsc_monitor
    import llsc_monitor_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int ACK_TIMEOUT = c_ack_timeout_def
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ll_req_i,
    input  logic [ADDR_W-1:0] ll_addr_i,
    input  logic              sc_req_i,
    input  logic [ADDR_W-1:0] sc_addr_i,
    input  logic [31:0]       sc_data_i,
    input  logic              snoop_we_i,
    input  logic [ADDR_W-1:0] snoop_addr_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic              mem_ack_i,
    output logic              LLbit_o,
    output logic [ADDR_W-1:0] link_addr_o,
    output logic              sc_done_o,
    output logic              sc_result_o,
    output logic              stall_req_o,
    output logic              bus_err_o
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_next_state;
    logic [ADDR_W-1:0]    r_link_addr;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [31:0]          r_mem_data;
    logic                 r_result;
    logic                 r_flush_pend;
    logic                 r_bus_err;

    logic w_accepting;
    logic w_sc_hit;
    logic w_snoop_hit;
    logic w_sc_pass;
    logic w_ll_take;
    logic w_expired;
    logic w_ack_timeout;

    assign w_accepting   = (r_state == c_st_idle) || (r_state == c_st_linked);
    assign w_sc_hit      = (sc_addr_i[ADDR_W-1:2] == r_link_addr[ADDR_W-1:2]);
    assign w_snoop_hit   = snoop_we_i &&
                           (snoop_addr_i[ADDR_W-1:2] == r_link_addr[ADDR_W-1:2]);
    assign w_sc_pass     = (r_state == c_st_linked) && w_sc_hit && !w_snoop_hit && !flush;
    assign w_ll_take     = w_accepting && ll_req_i && !sc_req_i && !flush;
    assign w_ack_timeout = (r_state == c_st_sc_write) && !mem_ack_i && w_expired;

    llsc_timeout_cnt #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (r_state != c_st_sc_write),
        .enable  (r_state == c_st_sc_write),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (sc_req_i)      w_next_state = c_st_sc_done;
                else if (flush)    w_next_state = c_st_idle;
                else if (ll_req_i) w_next_state = c_st_linked;
            end
            c_st_linked: begin
                if (sc_req_i)         w_next_state = w_sc_pass ? c_st_sc_write : c_st_sc_done;
                else if (flush)       w_next_state = c_st_idle;
                else if (ll_req_i)    w_next_state = c_st_linked;
                else if (w_snoop_hit) w_next_state = c_st_idle;
            end
            c_st_sc_write: begin
                if (mem_ack_i || w_expired) w_next_state = c_st_sc_done;
            end
            c_st_sc_done: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_link_addr  <= '0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_result     <= c_sc_fail;
            r_flush_pend <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            if (w_ll_take) begin
                r_link_addr <= {ll_addr_i[ADDR_W-1:2], 2'b00};
            end
            if (sc_req_i && w_sc_pass) begin
                r_mem_addr <= sc_addr_i;
                r_mem_data <= sc_data_i;
            end
            // Only an acked write reaches SC_DONE with success; every other
            // entry into SC_DONE is a failure.
            r_result  <= ((r_state == c_st_sc_write) && mem_ack_i) ? c_sc_ok : c_sc_fail;
            r_bus_err <= w_ack_timeout;
            if (r_state == c_st_sc_done) begin
                r_flush_pend <= 1'b0;
            end else if ((r_state == c_st_sc_write) && flush) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        LLbit_o     = (r_state == c_st_linked);
        mem_we_o    = (r_state == c_st_sc_write);
        sc_done_o   = (r_state == c_st_sc_done) && !r_flush_pend;
        sc_result_o = sc_done_o && r_result;
        // Stall is gated by reset so every output is low while rst is held.
        stall_req_o = !rst && ((r_state == c_st_sc_write) || (w_accepting && sc_req_i));
    end

    assign mem_addr_o  = r_mem_addr;
    assign mem_data_o  = r_mem_data;
    assign link_addr_o = r_link_addr;
    assign bus_err_o   = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_llsc_monitor.sv
//==============================================================================
// Module      : tb_llsc_monitor
// Description : Self-checking bench for llsc_monitor with directed scenarios
//               and randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_llsc_monitor;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              ll_req_i = 1'b0;
    logic [ADDR_W-1:0] ll_addr_i = '0;
    logic              sc_req_i = 1'b0;
    logic [ADDR_W-1:0] sc_addr_i = '0;
    logic [31:0]       sc_data_i = '0;
    logic              snoop_we_i = 1'b0;
    logic [ADDR_W-1:0] snoop_addr_i = '0;
    logic              mem_ack_i = 1'b0;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic              LLbit_o;
    logic [ADDR_W-1:0] link_addr_o;
    logic              sc_done_o;
    logic              sc_result_o;
    logic              stall_req_o;
    logic              bus_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    llsc_monitor #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ll_req_i(ll_req_i), .ll_addr_i(ll_addr_i),
        .sc_req_i(sc_req_i), .sc_addr_i(sc_addr_i), .sc_data_i(sc_data_i),
        .snoop_we_i(snoop_we_i), .snoop_addr_i(snoop_addr_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i), .LLbit_o(LLbit_o), .link_addr_o(link_addr_o),
        .sc_done_o(sc_done_o), .sc_result_o(sc_result_o),
        .stall_req_o(stall_req_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: a reservation, an outstanding write and a pending
    // completion report, advanced once per rising edge.
    bit          m_have_link, m_writing, m_report, m_report_ok, m_quiet, m_bus_err;
    logic [29:0] m_link_word;
    logic [31:0] m_waddr, m_wdata;
    int          m_waited;

    task automatic model_reset();
        m_have_link = 0; m_writing = 0; m_report = 0; m_report_ok = 0;
        m_quiet = 0; m_bus_err = 0; m_link_word = '0; m_waited = 0;
    endtask

    task automatic model_step();
        m_bus_err = 0;
        if (m_report) begin
            m_report = 0;
            m_quiet  = 0;
        end else if (m_writing) begin
            if (flush) m_quiet = 1;
            if (mem_ack_i) begin
                m_writing = 0; m_report = 1; m_report_ok = 1;
            end else if (m_waited + 1 == TIMEOUT) begin
                m_writing = 0; m_report = 1; m_report_ok = 0; m_bus_err = 1;
            end else begin
                m_waited++;
            end
        end else if (sc_req_i) begin
            if (m_have_link && sc_addr_i[31:2] == m_link_word && !flush &&
                !(snoop_we_i && snoop_addr_i[31:2] == m_link_word)) begin
                m_writing = 1; m_waited = 0; m_waddr = sc_addr_i; m_wdata = sc_data_i;
            end else begin
                m_report = 1; m_report_ok = 0;
            end
            m_have_link = 0;
        end else if (flush) begin
            m_have_link = 0;
        end else if (ll_req_i) begin
            m_have_link = 1; m_link_word = ll_addr_i[31:2];
        end else if (snoop_we_i && snoop_addr_i[31:2] == m_link_word) begin
            m_have_link = 0;
        end
    endtask

    function automatic logic [5:0] model_flags();
        logic done;
        done = m_report && !m_quiet;
        return {m_have_link, m_writing, done, done && m_report_ok,
                m_writing || (!m_report && sc_req_i), m_bus_err};
    endfunction

    function automatic logic [5:0] dut_flags();
        return {LLbit_o, mem_we_o, sc_done_o, sc_result_o, stall_req_o, bus_err_o};
    endfunction

    // One cycle: commit the previous inputs into the model at the edge, then
    // drive the new inputs after the falling edge and let outputs settle.
    task automatic apply(input bit ll, input logic [31:0] lla, input bit sc,
                         input logic [31:0] sca, input logic [31:0] scd,
                         input bit sn, input logic [31:0] sna, input bit fl, input bit ack);
        @(posedge clk);
        model_step();
        @(negedge clk);
        ll_req_i = ll; ll_addr_i = lla; sc_req_i = sc; sc_addr_i = sca; sc_data_i = scd;
        snoop_we_i = sn; snoop_addr_i = sna; flush = fl; mem_ack_i = ack;
        #1;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (dut_flags() !== 6'b0 || link_addr_o !== '0 || mem_addr_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got flags=%b link=%h maddr=%h exp flags=000000 link=0 maddr=0",
                     dut_flags(), link_addr_o, mem_addr_o);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_sc_success();
        apply(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (LLbit_o !== 1'b0) begin n_fail++; $display("FAIL ll_latency got=%b exp=0", LLbit_o); end
        apply(0, 0, 1, 32'h100, 32'hCAFE_F00D, 0, 0, 0, 0);
        n_tests++;
        if (LLbit_o !== 1'b1 || link_addr_o !== 32'h100 || stall_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL link_set got ll=%b link=%h stall=%b exp ll=1 link=100 stall=1",
                     LLbit_o, link_addr_o, stall_req_o);
        end
        idle();
        n_tests++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_data_o !== 32'hCAFE_F00D || LLbit_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sc_write got we=%b addr=%h data=%h ll=%b exp we=1 addr=100 data=cafef00d ll=0",
                     mem_we_o, mem_addr_o, mem_data_o, LLbit_o);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        n_tests++;
        if (sc_done_o !== 1'b1 || sc_result_o !== 1'b1 || mem_we_o !== 1'b0 || stall_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sc_success_done got done=%b res=%b we=%b stall=%b exp 1 1 0 0",
                     sc_done_o, sc_result_o, mem_we_o, stall_req_o);
        end
        idle();
        n_tests++;
        if (sc_done_o !== 1'b0 || LLbit_o !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle got done=%b ll=%b exp 0 0", sc_done_o, LLbit_o);
        end
    endtask

    task automatic test_snoop_fail();
        apply(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 1, 32'h102, 0, 0);
        apply(0, 0, 1, 32'h100, 32'h1234, 0, 0, 0, 0);
        n_tests++;
        if (LLbit_o !== 1'b0 || stall_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL snoop_break got ll=%b stall=%b exp ll=0 stall=1", LLbit_o, stall_req_o);
        end
        idle();
        n_tests++;
        if (sc_done_o !== 1'b1 || sc_result_o !== 1'b0 || mem_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL snoop_sc_fail got done=%b res=%b we=%b exp 1 0 0", sc_done_o, sc_result_o, mem_we_o);
        end
        idle();
    endtask

    task automatic test_word_match();
        apply(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 1, 32'h104, 0, 0);
        apply(0, 0, 1, 32'h103, 32'h5A5A_0001, 0, 0, 0, 0);
        n_tests++;
        if (LLbit_o !== 1'b1) begin n_fail++; $display("FAIL snoop_other_word got ll=%b exp=1", LLbit_o); end
        idle();
        n_tests++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== 32'h103 || mem_data_o !== 32'h5A5A_0001) begin
            n_fail++;
            $display("FAIL word_match_write got we=%b addr=%h data=%h exp we=1 addr=103 data=5a5a0001",
                     mem_we_o, mem_addr_o, mem_data_o);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        n_tests++;
        if (sc_done_o !== 1'b1 || sc_result_o !== 1'b1) begin
            n_fail++;
            $display("FAIL word_match_done got done=%b res=%b exp 1 1", sc_done_o, sc_result_o);
        end
        idle();
    endtask

    task automatic test_timeout();
        int we_cycles = 0;
        int errs = 0;
        apply(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 1, 32'h200, 32'hDEAD_BEEF, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            idle();
            if (mem_we_o) we_cycles++;
            if (bus_err_o) begin
                errs++;
                n_tests++;
                if (sc_done_o !== 1'b1 || sc_result_o !== 1'b0 || mem_we_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_done got done=%b res=%b we=%b exp 1 0 0",
                             sc_done_o, sc_result_o, mem_we_o);
                end
            end
        end
        n_tests++;
        if (we_cycles != TIMEOUT || errs != 1) begin
            n_fail++;
            $display("FAIL timeout_length got we_cycles=%0d bus_err_pulses=%0d exp %0d 1",
                     we_cycles, errs, TIMEOUT);
        end
    endtask

    task automatic test_flush_write();
        int dones = 0;
        apply(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 1, 32'h100, 32'h0BAD_F00D, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        n_tests++;
        if (mem_we_o !== 1'b1 || stall_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_keeps_write got we=%b stall=%b exp 1 1", mem_we_o, stall_req_o);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            idle();
            if (sc_done_o || mem_we_o || LLbit_o || stall_req_o) dones++;
        end
        n_tests++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL flush_suppress got active_cycles=%0d exp=0", dones);
        end
    endtask

    task automatic test_rst_mid_write();
        apply(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 1, 32'h100, 32'h7777_0000, 0, 0, 0, 0);
        idle();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (dut_flags() !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset got flags=%b exp=000000", dut_flags());
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle();
        idle();
        n_tests++;
        if (sc_done_o !== 1'b0 || mem_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done got done=%b we=%b exp 0 0", sc_done_o, mem_we_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [5] = '{32'h100, 32'h102, 32'h103, 32'h104, 32'h200};
        logic [5:0]  exp_flags;
        for (int i = 0; i < 600; i++) begin
            apply($urandom_range(0, 99) < 25, pool[$urandom_range(0, 4)],
                  $urandom_range(0, 99) < 15, pool[$urandom_range(0, 4)], $urandom,
                  $urandom_range(0, 99) < 25, pool[$urandom_range(0, 4)],
                  $urandom_range(0, 99) < 5,  $urandom_range(0, 99) < 20);
            exp_flags = model_flags();
            n_tests++;
            if (dut_flags() !== exp_flags) begin
                n_fail++;
                $display("FAIL rand_flags cycle=%0d got {ll,we,done,res,stall,err}=%b exp=%b",
                         i, dut_flags(), exp_flags);
            end
            if (m_have_link) begin
                n_tests++;
                if (link_addr_o !== {m_link_word, 2'b00}) begin
                    n_fail++;
                    $display("FAIL rand_link cycle=%0d got=%h exp=%h", i, link_addr_o, {m_link_word, 2'b00});
                end
            end
            if (m_writing) begin
                n_tests++;
                if (mem_addr_o !== m_waddr || mem_data_o !== m_wdata) begin
                    n_fail++;
                    $display("FAIL rand_write cycle=%0d got addr=%h data=%h exp addr=%h data=%h",
                             i, mem_addr_o, mem_data_o, m_waddr, m_wdata);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sc_success();
        test_snoop_fail();
        test_word_match();
        test_timeout();
        test_flush_write();
        test_rst_mid_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
